uart_tx_frame_ctrl: RTL and testbench
=====================================

# uart_tx_frame_ctrl

Transmit frame controller for the UART. Sequences one serial character at a time from a single-entry transmit holding register (THR) through a transmit shift register (TSR) onto the TXD line, using the line-control fields WLS/STB/PEN/EPS/SP/BC as the frame format. It sits between the register-write path (THR at address 00h) and the pin, and runs off the 16x baud enable from the baud generator.

## Interface
- No parameters; oversample ratio fixed at 16 (package constant).
- m_clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- baud_x16  in  1  one-cycle enable, 16 per bit period.
- WLS  in  2  word length: 00=5, 01=6, 10=7, 11=8 data bits.
- STB  in  1  0=1 stop bit; 1=2 stop bits (1.5 when WLS=00).
- PEN, EPS, SP  in  1 each  parity enable / even select / stick parity.
- BC  in  1  break control.
- thr_data  in  8  character to send; bits above word length ignored.
- thr_valid  in  1  write strobe for thr_data.
- thr_ready  out  1  THR empty; a write is accepted when thr_valid & thr_ready.
- txd  out  1  serial output, idle high.
- thre  out  1  THR empty (equals thr_ready).
- temt  out  1  THR and TSR both empty, line idle.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: if THR full, on next baud_x16 tick load TSR from THR, latch WLS/STB/PEN/EPS/SP into frame-config registers, clear THR, go to START.
- START: txd=0 for 16 ticks -> DATA.
- DATA: data bits sent LSB first, 16 ticks each; after bit (WLS+4) -> PARITY if latched PEN else STOP.
- PARITY bit: SP=0: EPS=1 even (XOR of used data bits), EPS=0 odd (inverted XOR). SP=1: bit = ~EPS (EPS=1 -> 0, EPS=0 -> 1). Only the used data bits contribute.
- STOP: txd=1 for 16, 24 (STB=1, WLS=00) or 32 (STB=1, other) ticks; then -> START if THR full (back-to-back, no idle gap), else IDLE.
- Frame format is latched at frame start; LCR changes mid-frame affect the next frame only.
- thr_ready/thre = ~thr_full; temt = ~thr_full & state==IDLE.
- THR write and TSR load in the same cycle impossible: write needs thr_full=0, load needs thr_full=1. No bypass of THR.
- Writes while thr_ready=0 are dropped.

## Timing
- Reset values: txd=1, thr_ready=1, thre=1, temt=1, state=IDLE, counters 0, THR/TSR cleared.
- Reset mid-frame: aborts immediately; txd=1 on the next edge, pending THR content discarded.
- A write at edge N makes thr_full=1 at N+1; START begins on the first baud_x16 after that; txd falls on the clock edge following that tick.
- thr_ready reasserts on the edge the TSR loads, so the next character may be written during the current frame.
- Tick counter 4-bit, wraps 15->0 at each bit boundary; bit counter 3-bit; stop counter 6-bit.
- Outputs all registered; txd has no combinational path from inputs, except BC (see Configuration), which is also registered.

## Configuration
- UART_TX_BREAK_EN defined: while BC=1, txd is forced 0 (registered, one-cycle latency); the state machine keeps running and frames are consumed normally; txd returns to the sequenced value on the cycle after BC falls.
- Not defined: BC ignored; txd always follows the state machine.

## Structure
- Shared package uart_pkg: state enum, WLS encodings, OVERSAMPLE=16, stop-tick constants 16/24/32.
- One sub-module: uart_tx_parity (combinational parity from TSR data, word length, EPS, SP).

## Test plan
- WLS=11, STB=0, PEN=0, write 8'hA5 -> txd: 0, 1,0,1,0,0,1,0,1, 1; each bit 16 ticks; temt=1 after 160 ticks.
- WLS=00, STB=1, PEN=1, EPS=1, write 8'hFF -> 5 ones, parity 1, stop 24 ticks; bits 7:5 ignored.
- PEN=1, SP=1, EPS=0, WLS=10, write 8'h00 -> parity bit 1; then EPS=1 -> parity bit 0.
- Write 8'h55 then 8'h0F while first frame active -> second START immediately follows first STOP, no idle tick; third write while thr_ready=0 dropped.
- Reset asserted mid-DATA of 8'h3C -> next edge txd=1, thr_ready=1, temt=1; no residual frame.
- With UART_TX_BREAK_EN, BC=1 during a frame -> txd=0 throughout, thre/temt still follow frame completion.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path: FSM state encoding,
// word-length codes, oversample ratio, stop-bit durations and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    localparam logic [1:0] WLS_5 = 2'b00;
    localparam logic [1:0] WLS_6 = 2'b01;
    localparam logic [1:0] WLS_7 = 2'b10;
    localparam logic [1:0] WLS_8 = 2'b11;

    localparam int unsigned OVERSAMPLE = 16;
    localparam logic [3:0]  TICK_LAST  = 4'(OVERSAMPLE - 1);

    localparam logic [5:0] STOP_TICKS_1   = 6'd16;
    localparam logic [5:0] STOP_TICKS_1P5 = 6'd24;
    localparam logic [5:0] STOP_TICKS_2   = 6'd32;

    function automatic logic [7:0] word_mask(input logic [1:0] wls);
        logic [7:0] mask;
        case (wls)
            WLS_5:   mask = 8'h1F;
            WLS_6:   mask = 8'h3F;
            WLS_7:   mask = 8'h7F;
            WLS_8:   mask = 8'hFF;
            default: mask = 8'hFF;
        endcase
        return mask;
    endfunction

    // Stick parity ignores the data entirely; otherwise only used bits count.
    function automatic logic tx_parity(input logic [7:0] data, input logic [1:0] wls,
                                       input logic eps, input logic sp);
        logic x;
        logic p;
        x = ^(data & word_mask(wls));
        if (sp) begin
            p = ~eps;
        end else if (eps) begin
            p = x;
        end else begin
            p = ~x;
        end
        return p;
    endfunction

    // Last stop-counter value; counting starts at zero so this is duration - 1.
    function automatic logic [5:0] stop_last(input logic stb, input logic [1:0] wls);
        logic [5:0] last;
        if (!stb) begin
            last = STOP_TICKS_1 - 6'd1;
        end else if (wls == WLS_5) begin
            last = STOP_TICKS_1P5 - 6'd1;
        end else begin
            last = STOP_TICKS_2 - 6'd1;
        end
        return last;
    endfunction

endpackage

// File: rtl/uart_tx_parity.sv
// Combinational parity for the character held in the transmit shift register,
// using the frame format latched at frame start.
module uart_tx_parity (
    input  logic [7:0] data,
    input  logic [1:0] wls,
    input  logic       eps,
    input  logic       sp,
    output logic       parity
);
    import uart_pkg::*;

    assign parity = tx_parity(data, wls, eps, sp);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: THR -> TSR -> txd, paced by the 16x baud enable.
// Optional UART_TX_BREAK_EN: BC forces txd low (registered) while the FSM keeps running.
module uart_tx_frame_ctrl (
    input  logic       m_clk,
    input  logic       reset,
    input  logic       baud_x16,
    input  logic [1:0] WLS,
    input  logic       STB,
    input  logic       PEN,
    input  logic       EPS,
    input  logic       SP,
    input  logic       BC,
    input  logic [7:0] thr_data,
    input  logic       thr_valid,
    output logic       thr_ready,
    output logic       txd,
    output logic       thre,
    output logic       temt
);
    import uart_pkg::*;

    tx_state_e  state_r;
    logic [3:0] tick_cnt_r;
    logic [2:0] bit_cnt_r;
    logic [5:0] stop_cnt_r;
    logic [7:0] thr_r;
    logic [7:0] tsr_r;
    logic       thr_empty_r;
    logic       temt_r;
    logic       seq_txd_r;
    logic [1:0] wls_r;
    logic       stb_r;
    logic       pen_r;
    logic       eps_r;
    logic       sp_r;

    logic       parity_s;
    logic       wr_accept_s;
    logic       bit_end_s;
    logic       last_bit_s;
    logic [2:0] bit_nxt_s;
    logic [5:0] stop_last_s;
    logic       stop_done_s;
    logic       load_s;

    uart_tx_parity u_parity (
        .data   (tsr_r),
        .wls    (wls_r),
        .eps    (eps_r),
        .sp     (sp_r),
        .parity (parity_s)
    );

    assign wr_accept_s = thr_valid & thr_empty_r;
    assign bit_end_s   = baud_x16 & (tick_cnt_r == TICK_LAST);
    assign last_bit_s  = (bit_cnt_r == ({1'b0, wls_r} + 3'd4));
    assign bit_nxt_s   = bit_cnt_r + 3'd1;
    assign stop_last_s = stop_last(stb_r, wls_r);
    assign stop_done_s = baud_x16 & (stop_cnt_r == stop_last_s);

    // TSR load: from idle on a tick, or straight out of STOP for back-to-back frames.
    always_comb begin
        load_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (baud_x16 && !thr_empty_r) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            ST_STOP: begin
                if (stop_done_s && !thr_empty_r) begin
                    load_s = 1'b1;
                end else begin
                    load_s = 1'b0;
                end
            end
            default: load_s = 1'b0;
        endcase
    end

    // Holding register and the empty flags derived from it.
    always_ff @(posedge m_clk) begin
        if (reset) begin
            thr_r       <= 8'd0;
            thr_empty_r <= 1'b1;
            temt_r      <= 1'b1;
        end else if (load_s) begin
            thr_r       <= 8'd0;
            thr_empty_r <= 1'b1;
            temt_r      <= 1'b0;
        end else if (wr_accept_s) begin
            thr_r       <= thr_data;
            thr_empty_r <= 1'b0;
            temt_r      <= 1'b0;
        end else if (state_r == ST_STOP && stop_done_s) begin
            temt_r      <= 1'b1;
        end
    end

    // Frame sequencer: counters, latched frame format and the sequenced line level.
    always_ff @(posedge m_clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            tick_cnt_r <= 4'd0;
            bit_cnt_r  <= 3'd0;
            stop_cnt_r <= 6'd0;
            tsr_r      <= 8'd0;
            wls_r      <= 2'b00;
            stb_r      <= 1'b0;
            pen_r      <= 1'b0;
            eps_r      <= 1'b0;
            sp_r       <= 1'b0;
            seq_txd_r  <= 1'b1;
        end else if (load_s) begin
            state_r    <= ST_START;
            tick_cnt_r <= 4'd0;
            bit_cnt_r  <= 3'd0;
            stop_cnt_r <= 6'd0;
            tsr_r      <= thr_r;
            wls_r      <= WLS;
            stb_r      <= STB;
            pen_r      <= PEN;
            eps_r      <= EPS;
            sp_r       <= SP;
            seq_txd_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    seq_txd_r <= 1'b1;
                end
                ST_START: begin
                    if (baud_x16) begin
                        tick_cnt_r <= tick_cnt_r + 4'd1;
                    end
                    if (bit_end_s) begin
                        state_r   <= ST_DATA;
                        bit_cnt_r <= 3'd0;
                        seq_txd_r <= tsr_r[0];
                    end
                end
                ST_DATA: begin
                    if (baud_x16) begin
                        tick_cnt_r <= tick_cnt_r + 4'd1;
                    end
                    if (bit_end_s) begin
                        if (!last_bit_s) begin
                            bit_cnt_r <= bit_nxt_s;
                            seq_txd_r <= tsr_r[bit_nxt_s];
                        end else if (pen_r) begin
                            state_r   <= ST_PARITY;
                            seq_txd_r <= parity_s;
                        end else begin
                            state_r    <= ST_STOP;
                            stop_cnt_r <= 6'd0;
                            seq_txd_r  <= 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (baud_x16) begin
                        tick_cnt_r <= tick_cnt_r + 4'd1;
                    end
                    if (bit_end_s) begin
                        state_r    <= ST_STOP;
                        stop_cnt_r <= 6'd0;
                        seq_txd_r  <= 1'b1;
                    end
                end
                ST_STOP: begin
                    seq_txd_r <= 1'b1;
                    if (stop_done_s) begin
                        state_r    <= ST_IDLE;
                        stop_cnt_r <= 6'd0;
                    end else if (baud_x16) begin
                        stop_cnt_r <= stop_cnt_r + 6'd1;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    seq_txd_r <= 1'b1;
                end
            endcase
        end
    end

`ifdef UART_TX_BREAK_EN
    logic brk_r;

    // Registered break request; gates the line low one cycle after BC.
    always_ff @(posedge m_clk) begin
        if (reset) begin
            brk_r <= 1'b0;
        end else begin
            brk_r <= BC;
        end
    end

    assign txd = seq_txd_r & ~brk_r;
`else
    logic unused_bc_s;
    assign unused_bc_s = BC;
    assign txd         = seq_txd_r;
`endif

    assign thr_ready = thr_empty_r;
    assign thre      = thr_empty_r;
    assign temt      = temt_r;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Directed self-checking bench for uart_tx_frame_ctrl; one baud tick every third clock.
module tb_uart_tx_frame_ctrl;

    logic       m_clk = 1'b0;
    logic       reset;
    logic       baud_x16;
    logic [1:0] WLS;
    logic       STB, PEN, EPS, SP, BC;
    logic [7:0] thr_data;
    logic       thr_valid;
    logic       thr_ready, txd, thre, temt;

    int total = 0;
    int bad   = 0;

    always #5 m_clk = ~m_clk;

    uart_tx_frame_ctrl dut (
        .m_clk     (m_clk),
        .reset     (reset),
        .baud_x16  (baud_x16),
        .WLS       (WLS),
        .STB       (STB),
        .PEN       (PEN),
        .EPS       (EPS),
        .SP        (SP),
        .BC        (BC),
        .thr_data  (thr_data),
        .thr_valid (thr_valid),
        .thr_ready (thr_ready),
        .txd       (txd),
        .thre      (thre),
        .temt      (temt)
    );

    task automatic cyc();
        @(posedge m_clk);
        #1;
    endtask

    task automatic one_tick();
        baud_x16 = 1'b0;
        cyc();
        cyc();
        baud_x16 = 1'b1;
        cyc();
        baud_x16 = 1'b0;
    endtask

    task automatic write(input logic [7:0] d);
        thr_data  = d;
        thr_valid = 1'b1;
        cyc();
        thr_valid = 1'b0;
    endtask

    task automatic set_lcr(input logic [1:0] w, input logic s, input logic p,
                           input logic e, input logic k);
        WLS = w; STB = s; PEN = p; EPS = e; SP = k;
    endtask

    // Ticks t0..t1 of a frame loaded at tick 0; bits[0] is the start bit.
    task automatic seg(input logic [15:0] bits, input int nbits, input int t0,
                       input int t1, input string nm);
        int first_bad;
        logic exp_v, got_v, exp_bad;
        logic [15:0] sh;
        first_bad = -1;
        got_v = 1'b0;
        exp_bad = 1'b0;
        for (int t = t0; t <= t1; t++) begin
            one_tick();
            sh = bits >> (t / 16);
            exp_v = (t < 16 * nbits) ? sh[0] : 1'b1;
            if (txd !== exp_v && first_bad < 0) begin
                first_bad = t;
                got_v = txd;
                exp_bad = exp_v;
            end
        end
        total++;
        if (first_bad >= 0) begin
            bad++;
            $display("FAIL %s: txd at tick %0d was %b, expected %b", nm, first_bad, got_v, exp_bad);
        end
    endtask

    task automatic frame(input logic [15:0] bits, input int nbits, input int stop,
                         input string nm);
        seg(bits, nbits, 0, 16 * nbits + stop - 1, nm);
        total++;
        if (temt !== 1'b0) begin
            bad++; $display("FAIL %s_temt_busy: temt=%b expected 0", nm, temt);
        end
        one_tick();
        total++;
        if (temt !== 1'b1) begin
            bad++; $display("FAIL %s_temt_done: temt=%b expected 1", nm, temt);
        end
        total++;
        if (txd !== 1'b1) begin
            bad++; $display("FAIL %s_txd_idle: txd=%b expected 1", nm, txd);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; baud_x16 = 1'b0; BC = 1'b0; thr_valid = 1'b0; thr_data = 8'h00;
        set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(); cyc(); cyc();
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL reset_txd: txd=%b expected 1", txd); end
        total++; if (thr_ready !== 1'b1) begin bad++; $display("FAIL reset_thr_ready: %b expected 1", thr_ready); end
        total++; if (thre !== 1'b1) begin bad++; $display("FAIL reset_thre: %b expected 1", thre); end
        total++; if (temt !== 1'b1) begin bad++; $display("FAIL reset_temt: %b expected 1", temt); end
        reset = 1'b0;
        cyc();
    endtask

    task automatic test_8n1();
        logic [15:0] b;
        b = {7'd0, 8'hA5, 1'b0};
        set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        write(8'hA5);
        total++; if (thr_ready !== 1'b0) begin bad++; $display("FAIL a5_accept: thr_ready=%b expected 0", thr_ready); end
        total++; if (temt !== 1'b0) begin bad++; $display("FAIL a5_temt: temt=%b expected 0", temt); end
        seg(b, 9, 0, 0, "a5_start");
        total++; if (thr_ready !== 1'b1) begin bad++; $display("FAIL a5_load: thr_ready=%b expected 1", thr_ready); end
        set_lcr(2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
        seg(b, 9, 1, 159, "a5_frame");
        total++; if (temt !== 1'b0) begin bad++; $display("FAIL a5_temt_busy: temt=%b expected 0", temt); end
        one_tick();
        total++; if (temt !== 1'b1) begin bad++; $display("FAIL a5_temt_160: temt=%b expected 1", temt); end
    endtask

    task automatic test_parity();
        set_lcr(2'b00, 1'b1, 1'b1, 1'b1, 1'b0);
        write(8'hFF);
        frame({9'd0, 1'b1, 5'h1F, 1'b0}, 7, 24, "ff_5e_1p5");
        set_lcr(2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
        write(8'h47);
        frame({8'd0, 1'b0, 6'b000111, 1'b0}, 8, 32, "h47_6o_2");
        set_lcr(2'b10, 1'b0, 1'b1, 1'b0, 1'b1);
        write(8'h00);
        frame({7'd0, 1'b1, 7'h00, 1'b0}, 9, 16, "stick_eps0");
        set_lcr(2'b10, 1'b0, 1'b1, 1'b1, 1'b1);
        write(8'h00);
        frame({7'd0, 1'b0, 7'h00, 1'b0}, 9, 16, "stick_eps1");
        write(8'h01);
        frame({7'd0, 1'b0, 7'h01, 1'b0}, 9, 16, "stick_eps1_d01");
    endtask

    task automatic test_back_to_back();
        logic [15:0] b1, b2;
        b1 = {7'd0, 8'h55, 1'b0};
        b2 = {7'd0, 8'h0F, 1'b0};
        set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        write(8'h55);
        seg(b1, 9, 0, 20, "b2b_first_a");
        total++; if (thr_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: thr_ready=%b expected 1", thr_ready); end
        write(8'h0F);
        total++; if (thr_ready !== 1'b0) begin bad++; $display("FAIL b2b_full: thr_ready=%b expected 0", thr_ready); end
        write(8'hAA);
        seg(b1, 9, 21, 159, "b2b_first_b");
        one_tick();
        total++; if (txd !== 1'b0) begin bad++; $display("FAIL b2b_no_gap: txd=%b expected 0", txd); end
        total++; if (temt !== 1'b0) begin bad++; $display("FAIL b2b_temt: temt=%b expected 0", temt); end
        total++; if (thre !== 1'b1) begin bad++; $display("FAIL b2b_thre: thre=%b expected 1", thre); end
        seg(b2, 9, 1, 159, "b2b_second");
        one_tick();
        total++; if (temt !== 1'b1) begin bad++; $display("FAIL b2b_temt_done: temt=%b expected 1", temt); end
        seg(16'd0, 0, 0, 39, "b2b_drop_third");
        total++; if (temt !== 1'b1) begin bad++; $display("FAIL b2b_idle: temt=%b expected 1", temt); end
    endtask

    task automatic test_reset_mid();
        set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
        write(8'h3C);
        seg({7'd0, 8'h3C, 1'b0}, 9, 0, 40, "rst_pre");
        write(8'h81);
        reset = 1'b1;
        cyc();
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL rst_mid_txd: txd=%b expected 1", txd); end
        total++; if (thr_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready: %b expected 1", thr_ready); end
        total++; if (temt !== 1'b1) begin bad++; $display("FAIL rst_mid_temt: %b expected 1", temt); end
        reset = 1'b0;
        seg(16'd0, 0, 0, 199, "rst_no_residual");
        total++; if (temt !== 1'b1) begin bad++; $display("FAIL rst_after_temt: %b expected 1", temt); end
    endtask

    task automatic test_break();
        set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef UART_TX_BREAK_EN
        BC = 1'b1;
        cyc();
        total++; if (txd !== 1'b0) begin bad++; $display("FAIL brk_idle: txd=%b expected 0", txd); end
        write(8'hA5);
        total++; if (thre !== 1'b0) begin bad++; $display("FAIL brk_thre_full: thre=%b expected 0", thre); end
        seg(16'd0, 16, 0, 0, "brk_load");
        total++; if (thre !== 1'b1) begin bad++; $display("FAIL brk_thre_load: thre=%b expected 1", thre); end
        seg(16'd0, 16, 1, 159, "brk_frame");
        total++; if (temt !== 1'b0) begin bad++; $display("FAIL brk_temt_busy: temt=%b expected 0", temt); end
        one_tick();
        total++; if (temt !== 1'b1) begin bad++; $display("FAIL brk_temt_done: temt=%b expected 1", temt); end
        BC = 1'b0;
        cyc();
        total++; if (txd !== 1'b1) begin bad++; $display("FAIL brk_release: txd=%b expected 1", txd); end
`else
        BC = 1'b1;
        write(8'hA5);
        frame({7'd0, 8'hA5, 1'b0}, 9, 16, "bc_ignored");
        BC = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_back_to_back();
        test_reset_mid();
        test_break();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
